// File: rtl/ahb2axi_bridge.sv
// ahb2axi_bridge
//   Single-beat AHB-Lite slave to AXI3 master bridge. Each accepted AHB
//   transfer becomes exactly one AXI transaction with length 0 and INCR
//   burst type. The AHB data phase is stretched until the AXI response
//   returns. A write completes on B and a read completes on R. An AXI error
//   response, or a transfer size wider than 64 bits, produces the two-cycle
//   AHB ERROR response.
//
// Ports
//   hclk, hreset      : clock, synchronous active-high reset
//   hsel .. hready    : AHB slave inputs (address/control, write data)
//   hreadyout, hresp,
//   hrdata            : AHB slave outputs
//   aw*/w*/b*         : AXI write channels (ID fixed to AXI_ID)
//   ar*/r*            : AXI read channels  (ID fixed to AXI_ID)
module ahb2axi_bridge #(
  parameter logic [7:0] AXI_ID = 8'h00
) (
  input  logic        hclk,
  input  logic        hreset,
  // AHB slave
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [63:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [63:0] hrdata,
  // AXI write address
  output logic [7:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [7:0]  wid,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [7:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  // AXI read address
  output logic [7:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [7:0]  rid,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {
    IDLE, WDAT, WADDR, WRESP, RADDR, RDAT, ERR1, ERR2
  } state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [63:0] hrdata_q;
  logic        aw_done_q, w_done_q;
  logic        accept;

  // IDs, burst response bits 0 and rlast are not needed for single-beat,
  // fixed-ID traffic.
  logic unused_inputs;
  assign unused_inputs = ^{htrans[0], bid, bresp[0], rid, rresp[0], rlast};

  assign accept = hsel & hready & htrans[1] & hreadyout;

  // Byte lanes for the addressed bytes within the 64-bit data bus.
  always_comb begin
    wstrb_d = '0;
    case (hsize)
      3'd0:    wstrb_d = 8'h01 << haddr[2:0];
      3'd1:    wstrb_d = 8'h03 << {haddr[2:1], 1'b0};
      3'd2:    wstrb_d = 8'h0F << {haddr[2], 2'b00};
      3'd3:    wstrb_d = 8'hFF;
      default: wstrb_d = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b0;
    hresp     = RESP_OKAY;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    case (state_q)
      // ERR2 is the completing cycle of an error. Like IDLE, it can take a
      // new address phase.
      IDLE, ERR2: begin
        hreadyout = 1'b1;
        if (state_q == ERR2) hresp = RESP_ERROR;
        state_d = IDLE;
        if (accept) begin
          if (hsize > 3'b011) state_d = ERR1;
          else if (hwrite)    state_d = WDAT;
          else                state_d = RADDR;
        end
      end
      WDAT: state_d = WADDR;
      WADDR: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
        if ((aw_done_q | awready) && (w_done_q | wready)) state_d = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) state_d = bresp[1] ? ERR1 : IDLE;
      end
      RADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RDAT;
      end
      RDAT: begin
        rready = 1'b1;
        if (rvalid) state_d = rresp[1] ? ERR1 : IDLE;
      end
      ERR1: begin
        hresp   = RESP_ERROR;
        state_d = ERR2;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      hrdata_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= haddr;
        size_q  <= hsize;
        wstrb_q <= wstrb_d;
      end
      if (state_q == WDAT) begin
        wdata_q   <= hwdata;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      // AW and W complete independently. Each valid drops after its own
      // handshake.
      if (state_q == WADDR) begin
        if (awvalid && awready) aw_done_q <= 1'b1;
        if (wvalid && wready)   w_done_q  <= 1'b1;
      end
      if (state_q == RDAT && rvalid) hrdata_q <= rdata;
    end
  end

  assign hrdata  = hrdata_q;
  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = '0;
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = '0;
  assign arsize  = size_q;
  assign arburst = 2'b01;

endmodule

// File: doc/ahb2axi_bridge.md
AHB2AXI_BRIDGE -- requirements
Module: ahb2axi_bridge

Interface
REQ-001 Parameter AXI_ID, default 8'h00, SHALL be the ID driven on awid/wid/arid.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 hclk  in  1  sole clock; all state updates on rising edge.
REQ-004 hreset  in  1  synchronous active-high reset.
REQ-005 hsel  in  1  AHB slave select.
REQ-006 haddr  in  32  AHB address.
REQ-007 htrans  in  2  AHB transfer type.
REQ-008 hwrite  in  1  1=write, 0=read.
REQ-009 hsize  in  3  AHB transfer size.
REQ-010 hwdata  in  64  AHB write data, valid in data phase.
REQ-011 hready  in  1  AHB bus ready (previous transfer done).
REQ-012 hreadyout  out  1  slave ready.
REQ-013 hresp  out  2  00=OKAY, 01=ERROR.
REQ-014 hrdata  out  64  read data.
REQ-015 AW out: awid[7:0], awaddr[31:0], awlen[7:0], awsize[2:0], awburst[1:0], awvalid; in: awready.
REQ-016 W out: wid[7:0], wdata[63:0], wstrb[7:0], wlast, wvalid; in: wready.
REQ-017 B in: bid[7:0], bresp[1:0], bvalid; out: bready.
REQ-018 AR out: arid[7:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arvalid; in: arready.
REQ-019 R in: rid[7:0], rdata[63:0], rresp[1:0], rlast, rvalid; out: rready.

Function
REQ-020 Address phase SHALL be accepted when hsel & hready & htrans[1] & hreadyout; haddr/hsize/hwrite registered.
REQ-021 IDLE/BUSY transfers or hsel=0 SHALL get zero-wait OKAY (hreadyout=1, hresp=00).
REQ-022 FSM states: IDLE, WDAT, WADDR, WRESP, RADDR, RDAT, ERR1, ERR2.
REQ-023 Accepted write -> WDAT; accepted read -> RADDR; hsize>3'b011 -> ERR1, no AXI traffic.
REQ-024 WDAT (first data-phase cycle): hreadyout=0, hwdata captured into wdata, -> WADDR.
REQ-025 WADDR: awvalid and wvalid=1; each deasserts independently after its valid&ready edge; both done -> WRESP.
REQ-026 WRESP: bready=1; on bvalid: bresp[1]=0 -> IDLE with hreadyout=1 one cycle, hresp=00; bresp[1]=1 -> ERR1.
REQ-027 RADDR: arvalid=1 from cycle after address phase until arready -> RDAT.
REQ-028 RDAT: rready=1; on rvalid, hrdata<=rdata; rresp[1]=0 -> IDLE with OKAY; rresp[1]=1 -> ERR1.
REQ-029 ERR1: hreadyout=0, hresp=01; ERR2: hreadyout=1, hresp=01; ERR2 -> IDLE.
REQ-030 hreadyout SHALL be 0 in WDAT, WADDR, WRESP, RADDR, RDAT, ERR1; 1 in IDLE, ERR2.
REQ-031 In the completing cycle (hreadyout=1) a new address phase SHALL be accepted (back-to-back).
REQ-032 awlen=arlen=0, awburst=arburst=2'b01, wlast=1, awsize/arsize=registered hsize, awaddr/araddr=registered haddr.
REQ-033 wstrb: size0 = 8'h01<<a[2:0]; size1 = 8'h03<<{a[2:1],1'b0}; size2 = 8'h0F<<{a[2],2'b00}; size3 = 8'hFF.
REQ-034 AXI valids SHALL stay stable with payload unchanged until handshake.
REQ-035 rid/bid SHALL be ignored; rlast ignored (single beat).
REQ-036 Minimum write latency: address phase, then hreadyout=0 for 3 cycles before OKAY when awready=wready=bvalid=1 immediately.

Reset
REQ-037 On hreset=1 at a clock edge: FSM=IDLE, hreadyout=1, hresp=00, hrdata=0, all AXI valids and bready/rready=0, wdata=0, wstrb=0.
REQ-038 Reset mid-transaction SHALL abandon it; no AXI valid asserted in the cycle after reset.

Verification
REQ-039 Write haddr=0x1000_0004, hsize=2, hwdata=0x1122334455667788, all AXI ready=1, bresp=00 -> awaddr=0x10000004, wstrb=0xF0, awsize=2, awlen=0, OKAY after 3 wait cycles.
REQ-040 Read haddr=0x2000_0000, hsize=3, arready delayed 4 cycles, rdata=0xDEADBEEF_CAFEF00D -> arvalid held 5 cycles, hrdata=0xDEADBEEFCAFEF00D, hresp=00.
REQ-041 Write with bresp=2'b10 -> hresp=01 two cycles, hreadyout 0 then 1.
REQ-042 hsize=3'b100 -> no awvalid/arvalid, two-cycle ERROR response.
REQ-043 wready 3 cycles after awready -> awvalid drops after its handshake, wvalid held until wready, single B wait.
REQ-044 Back-to-back write then read, hreset pulsed during RDAT -> next cycle arvalid=rready=0, hreadyout=1, hresp=00.
